// File: rtl/audio_processor.sv
// audio_processor
//   Frame-based audio effects engine. A 2048-sample frame of signed 16-bit
//   audio is loaded in 32-sample blocks, then processed one sample per cycle
//   through a 3-stage pipeline:
//     stage 1: pitch-shift resample (fetch input[src]) and gain lookup
//     stage 2: gain multiply, y1 = (x*g) >>> 7
//     stage 3: optional tremolo, saturate to 16 bits, write output[n]
//   done pulses for one cycle 2051 cycles after the edge that samples start.
//
//   Optional feature macro: TREMOLO_EN
//     defined   -> tremolo LFO stage present, tremolo enable is writable
//     undefined -> no tremolo hardware, tremolo writes ignored, y2 = y1
//
// Ports
//   clk                    sole clock, rising edge
//   rst_n                  synchronous reset, active-high (1 = reset)
//   start                  begin processing the stored frame (IDLE only)
//   data_wr_en/input_index/data_in
//                          write 32 samples into input block input_index
//   pitch_shift_wr_en/pitch_shift_semitones
//                          load signed semitone shift (clamped to +/-12 on use)
//   freq_coeff_wr_en/freq_coeff_index/freq_coeff_in
//                          write one Q1.7 gain coefficient
//   tremolo_enable_wr_en/tremolo_enable_in
//                          load tremolo enable
//   output_index/data_out  combinational read of 32 output samples
//   done                   one-cycle frame-complete pulse
module audio_processor (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         data_wr_en,
  input  logic [5:0]   input_index,
  input  logic [511:0] data_in,
  input  logic         pitch_shift_wr_en,
  input  logic [4:0]   pitch_shift_semitones,
  input  logic         freq_coeff_wr_en,
  input  logic [10:0]  freq_coeff_index,
  input  logic [7:0]   freq_coeff_in,
  input  logic         tremolo_enable_wr_en,
  input  logic         tremolo_enable_in,
  input  logic [5:0]   output_index,
  output logic [511:0] data_out,
  output logic         done
);

  localparam int unsigned FRAME_LEN = 2048;
  // Issue runs for counts 0..2047, then two more cycles drain the pipeline.
  localparam logic [11:0] LAST_CNT = 12'd2050;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;
  logic [11:0] cnt_q;
  logic        frame_end;
  logic        issue;
  logic        idle;
  logic        done_q;
  logic        frame_valid_q;

  logic signed [15:0] in_buf  [FRAME_LEN];
  logic signed [15:0] out_buf [FRAME_LEN];
  logic [7:0]         coeff_ram [FRAME_LEN];
  logic [FRAME_LEN-1:0] coeff_set;
  logic signed [4:0]  pitch_q;

  logic [10:0]        n;
  logic [12:0]        src;
  logic signed [15:0] x_sel;
  logic [7:0]         g_sel;

  logic               s1_valid, s2_valid;
  logic signed [15:0] s1_x;
  logic [7:0]         s1_g;
  logic [10:0]        s1_n, s2_n;
  logic signed [24:0] gain_prod;
  logic signed [17:0] y1, s2_y1;
  logic signed [18:0] y2;
  logic signed [15:0] y2_sat;

  // round(4096 * 2^(s/12)) for s clamped to [-12, 12]
  function automatic logic [13:0] pitch_ratio(input logic signed [4:0] semis);
    logic [4:0] k;
    if (semis > 5'sd12)       k = 5'd24;
    else if (semis < -5'sd12) k = 5'd0;
    else                      k = 5'(semis + 5'sd12);
    case (k)
      5'd0:  pitch_ratio = 14'd2048;
      5'd1:  pitch_ratio = 14'd2170;
      5'd2:  pitch_ratio = 14'd2299;
      5'd3:  pitch_ratio = 14'd2435;
      5'd4:  pitch_ratio = 14'd2580;
      5'd5:  pitch_ratio = 14'd2734;
      5'd6:  pitch_ratio = 14'd2896;
      5'd7:  pitch_ratio = 14'd3069;
      5'd8:  pitch_ratio = 14'd3251;
      5'd9:  pitch_ratio = 14'd3444;
      5'd10: pitch_ratio = 14'd3649;
      5'd11: pitch_ratio = 14'd3866;
      5'd12: pitch_ratio = 14'd4096;
      5'd13: pitch_ratio = 14'd4340;
      5'd14: pitch_ratio = 14'd4598;
      5'd15: pitch_ratio = 14'd4871;
      5'd16: pitch_ratio = 14'd5161;
      5'd17: pitch_ratio = 14'd5468;
      5'd18: pitch_ratio = 14'd5793;
      5'd19: pitch_ratio = 14'd6137;
      5'd20: pitch_ratio = 14'd6502;
      5'd21: pitch_ratio = 14'd6889;
      5'd22: pitch_ratio = 14'd7298;
      5'd23: pitch_ratio = 14'd7732;
      5'd24: pitch_ratio = 14'd8192;
      default: pitch_ratio = 14'd4096;
    endcase
  endfunction

  assign idle  = (state_q == IDLE);
  assign issue = (state_q == RUN) && !cnt_q[11];
  assign n     = cnt_q[10:0];
  assign done  = done_q;

  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= (state_q == RUN && state_d == RUN) ? cnt_q + 12'd1 : 12'd0;
      done_q   <= frame_end;
      if (frame_end) frame_valid_q <= 1'b1;
      s1_valid <= issue;
      s2_valid <= s1_valid;
    end
  end

  // Configuration registers; writes are only honoured while idle.
`ifdef TREMOLO_EN
  logic trem_en_q;
`else
  logic unused_tremolo;
  assign unused_tremolo = tremolo_enable_wr_en ^ tremolo_enable_in;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pitch_q   <= '0;
      coeff_set <= '0;
`ifdef TREMOLO_EN
      trem_en_q <= 1'b0;
`endif
    end else if (idle) begin
      if (pitch_shift_wr_en) pitch_q <= $signed(pitch_shift_semitones);
      if (freq_coeff_wr_en)  coeff_set[freq_coeff_index] <= 1'b1;
`ifdef TREMOLO_EN
      if (tremolo_enable_wr_en) trem_en_q <= tremolo_enable_in;
`endif
    end
  end

  // Sample and coefficient storage is deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n && idle && data_wr_en) begin
      for (int l = 0; l < 32; l++) begin
        in_buf[{input_index, 5'(l)}] <= data_in[16*l +: 16];
      end
    end
    if (!rst_n && idle && freq_coeff_wr_en) begin
      coeff_ram[freq_coeff_index] <= freq_coeff_in;
    end
    if (!rst_n && s2_valid) begin
      out_buf[s2_n] <= y2_sat;
    end
  end

  // Stage 1 inputs: resample position beyond the frame reads as silence.
  always_comb begin
    src   = 13'((25'(n) * 25'(pitch_ratio(pitch_q))) >> 12);
    x_sel = (src[12:11] != 2'b00) ? 16'sd0 : in_buf[src[10:0]];
    g_sel = coeff_set[n] ? coeff_ram[n] : 8'h80;
  end

  always_comb begin
    gain_prod = s1_x * $signed({1'b0, s1_g});
    y1        = 18'(gain_prod >>> 7);
  end

`ifdef TREMOLO_EN
  logic [8:0]         lfo;
  logic signed [27:0] trem_prod;

  // Triangle LFO between 0.5 and ~1.0 (Q0.9), period 1024 samples.
  always_comb begin
    lfo       = 9'd256 + (s2_n[9] ? 9'(8'd255 - s2_n[8:1]) : 9'(s2_n[8:1]));
    trem_prod = s2_y1 * $signed({1'b0, lfo});
    y2        = trem_en_q ? 19'(trem_prod >>> 9) : 19'(s2_y1);
  end
`else
  always_comb begin
    y2 = 19'(s2_y1);
  end
`endif

  always_comb begin
    if (y2 > 19'sd32767)       y2_sat = 16'sh7fff;
    else if (y2 < -19'sd32768) y2_sat = 16'sh8000;
    else                       y2_sat = y2[15:0];
  end

  // Pipeline data registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    s1_x  <= x_sel;
    s1_g  <= g_sel;
    s1_n  <= n;
    s2_y1 <= y1;
    s2_n  <= s1_n;
  end

  always_comb begin
    data_out = '0;
    for (int l = 0; l < 32; l++) begin
      if (frame_valid_q) data_out[16*l +: 16] = out_buf[{output_index, 5'(l)}];
    end
  end

endmodule

// File: tb/tb_audio_processor.sv
// tb_audio_processor
//   Scoreboard bench for audio_processor. Stimulus queues the expected output
//   samples of each frame; a monitor process waits for done, checks latency
//   and pulse width, then reads back and compares every queued sample.
module tb_audio_processor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         dataWrEn = 1'b0;
  logic [5:0]   inputIndex = '0;
  logic [511:0] dataIn = '0;
  logic         pitchWrEn = 1'b0;
  logic [4:0]   pitchSemis = '0;
  logic         coeffWrEn = 1'b0;
  logic [10:0]  coeffIndex = '0;
  logic [7:0]   coeffIn = '0;
  logic         tremWrEn = 1'b0;
  logic         tremIn = 1'b0;
  logic [5:0]   outputIndex = '0;
  logic [511:0] dataOut;
  logic         done;

  always #5 clk = ~clk;

  audio_processor dut (
    .clk                   (clk),
    .rst_n                 (rst),
    .start                 (start),
    .data_wr_en            (dataWrEn),
    .input_index           (inputIndex),
    .data_in               (dataIn),
    .pitch_shift_wr_en     (pitchWrEn),
    .pitch_shift_semitones (pitchSemis),
    .freq_coeff_wr_en      (coeffWrEn),
    .freq_coeff_index      (coeffIndex),
    .freq_coeff_in         (coeffIn),
    .tremolo_enable_wr_en  (tremWrEn),
    .tremolo_enable_in     (tremIn),
    .output_index          (outputIndex),
    .data_out              (dataOut),
    .done                  (done)
  );

  typedef struct {
    string       name;
    int          idx;
    logic [15:0] val;
  } expT;

  expT expQ[$];
  expT monEntry;
  int  checkCount = 0;
  int  failCount = 0;
  int  cycleCount = 0;
  int  startCycle = 0;
  int  framesPending = 0;
  bit  sbBusy = 1'b0;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input string name, input int idx, input int val);
    expT e;
    e.name = name;
    e.idx  = idx;
    e.val  = 16'(val);
    expQ.push_back(e);
  endtask

  // Monitor: every done pulse must match a started frame.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (framesPending == 0) begin
          checkOutput("unexpected_done", 512'(done), 512'(0));
        end else begin
          sbBusy = 1'b1;
          framesPending--;
          checkOutput("done_latency", 512'(cycleCount - startCycle), 512'(2051));
          @(negedge clk);
          checkOutput("done_pulse_width", 512'(done), 512'(0));
          while (expQ.size() > 0) begin
            monEntry = expQ.pop_front();
            outputIndex = 6'(monEntry.idx / 32);
            #1;
            checkOutput(monEntry.name, 512'(dataOut[(monEntry.idx % 32)*16 +: 16]), 512'(monEntry.val));
          end
          sbBusy = 1'b0;
        end
      end
    end
  end

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic writeBlock(input int k, input logic [511:0] d);
    @(negedge clk);
    dataWrEn = 1'b1;
    inputIndex = 6'(k);
    dataIn = d;
    @(negedge clk);
    dataWrEn = 1'b0;
  endtask

  task automatic loadRamp();
    logic [511:0] blk;
    for (int k = 0; k < 64; k++) begin
      for (int l = 0; l < 32; l++) blk[16*l +: 16] = 16'(32*k + l);
      writeBlock(k, blk);
    end
  endtask

  task automatic loadConst(input int v);
    logic [511:0] blk;
    for (int l = 0; l < 32; l++) blk[16*l +: 16] = 16'(v);
    for (int k = 0; k < 64; k++) writeBlock(k, blk);
  endtask

  task automatic writeCoeff(input int idx, input int val);
    @(negedge clk);
    coeffWrEn = 1'b1;
    coeffIndex = 11'(idx);
    coeffIn = 8'(val);
    @(negedge clk);
    coeffWrEn = 1'b0;
  endtask

  task automatic setPitch(input int s);
    @(negedge clk);
    pitchWrEn = 1'b1;
    pitchSemis = 5'(s);
    @(negedge clk);
    pitchWrEn = 1'b0;
  endtask

  task automatic setTremolo(input bit en);
    @(negedge clk);
    tremWrEn = 1'b1;
    tremIn = en;
    @(negedge clk);
    tremWrEn = 1'b0;
  endtask

  task automatic startFrame(input bit expectDone);
    if (expectDone) framesPending++;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    startCycle = cycleCount;
    start = 1'b0;
  endtask

  task automatic waitFrame(input string name);
    bit finished;
    finished = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (framesPending == 0 && !sbBusy) begin
        finished = 1'b1;
        break;
      end
    end
    checkOutput({name, "_completed"}, 512'(finished), 512'(1));
    if (!finished) begin
      expQ.delete();
      framesPending = 0;
    end
  endtask

  task automatic applyStimulus(input string name);
    startFrame(1'b1);
    waitFrame(name);
  endtask

  initial begin : stimulus
    // Reset state
    resetDut();
    #1;
    checkOutput("reset_done", 512'(done), 512'(0));
    checkOutput("reset_data_out", dataOut, 512'(0));

    // Abort: reset 100 cycles into a run gives no done and no output
    loadRamp();
    startFrame(1'b0);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2100) @(negedge clk);
    checkOutput("abort_done_low", 512'(done), 512'(0));
    checkOutput("abort_data_out_zero", dataOut, 512'(0));

    // Identity frame; writes and start issued mid-run must be ignored
    for (int i = 0; i < 32; i++) pushExp("f1_block0", i, i);
    pushExp("f1_s1000", 1000, 1000);
    pushExp("f1_s2047", 2047, 2047);
    startFrame(1'b1);
    repeat (5) @(negedge clk);
    dataWrEn = 1'b1; inputIndex = 6'd0; dataIn = '0;
    pitchWrEn = 1'b1; pitchSemis = 5'd12;
    coeffWrEn = 1'b1; coeffIndex = 11'd3; coeffIn = 8'd0;
    tremWrEn = 1'b1; tremIn = 1'b1;
    start = 1'b1;
    @(negedge clk);
    dataWrEn = 1'b0; pitchWrEn = 1'b0; coeffWrEn = 1'b0; tremWrEn = 1'b0; start = 1'b0;
    waitFrame("f1");

    // Upper half of the gain table zeroed
    for (int i = 1024; i < 2048; i++) writeCoeff(i, 0);
    pushExp("f2_s0", 0, 0);
    pushExp("f2_s500", 500, 500);
    pushExp("f2_s1023", 1023, 1023);
    pushExp("f2_s1024", 1024, 0);
    pushExp("f2_s2047", 2047, 0);
    applyStimulus("f2");

    // Octave up: output[n] = input[2n], silence past the frame end
    resetDut();
    setPitch(12);
    pushExp("f3_s0", 0, 0);
    pushExp("f3_s1", 1, 2);
    pushExp("f3_s1023", 1023, 2046);
    pushExp("f3_s1024", 1024, 0);
    pushExp("f3_s2047", 2047, 0);
    applyStimulus("f3");

    // -16 semitones clamps to an octave down: output[n] = input[n>>1]
    setPitch(-16);
    pushExp("f4_s0", 0, 0);
    pushExp("f4_s5", 5, 2);
    pushExp("f4_s2047", 2047, 1023);
    applyStimulus("f4");

    // Gain saturation and floor rounding
    resetDut();
    begin
      logic [511:0] blk;
      for (int l = 0; l < 32; l++) blk[16*l +: 16] = 16'(l);
      blk[16*5 +: 16] = 16'sd32767;
      blk[16*6 +: 16] = -16'sd1000;
      blk[16*7 +: 16] = -16'sd32768;
      blk[16*8 +: 16] = 16'sd3;
      blk[16*9 +: 16] = -16'sd3;
      writeBlock(0, blk);
    end
    writeCoeff(5, 8'hFF);
    writeCoeff(6, 8'h40);
    writeCoeff(7, 8'hFF);
    writeCoeff(8, 8'h40);
    writeCoeff(9, 8'h40);
    writeCoeff(11, 8'h80);
    pushExp("f5_sat_pos", 5, 32767);
    pushExp("f5_half_neg", 6, -500);
    pushExp("f5_sat_neg", 7, -32768);
    pushExp("f5_floor_pos", 8, 1);
    pushExp("f5_floor_neg", 9, -2);
    pushExp("f5_default_gain", 10, 10);
    pushExp("f5_unity_gain", 11, 11);
    applyStimulus("f5");

    // Tremolo on a constant 20000 input
    resetDut();
    loadConst(20000);
    setTremolo(1'b1);
`ifdef TREMOLO_EN
    pushExp("f6_s0", 0, 10000);
    pushExp("f6_s511", 511, 19960);
    pushExp("f6_s512", 512, 19960);
    pushExp("f6_s1023", 1023, 10000);
`else
    pushExp("f6_s0", 0, 20000);
    pushExp("f6_s511", 511, 20000);
    pushExp("f6_s1023", 1023, 20000);
`endif
    applyStimulus("f6");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
